// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a 2-entry skid buffer and branch resolution.
// Optional perf counters (stall_cnt, taken_cnt) enabled by EX_MEM_PERF_EN.
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] address,
  input  logic              zero,
  input  logic [DATA_W-1:0] resultOut,
  input  logic [DATA_W-1:0] pcout,
  input  logic              branch,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  input  logic [REG_W-1:0]  write_reg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] m_result,
  output logic [DATA_W-1:0] m_store_data,
  output logic [DATA_W-1:0] m_pc,
  output logic              m_mem_read,
  output logic              m_mem_write,
  output logic              m_reg_write,
  output logic              m_mem_to_reg,
  output logic [REG_W-1:0]  m_write_reg,
  output logic              pc_src,
  output logic [DATA_W-1:0] branch_target,
  output logic              flush
`ifdef EX_MEM_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       taken_cnt
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] sd;
    logic [DATA_W-1:0] pc;
    logic              mr;
    logic              mw;
    logic              rw;
    logic              m2r;
    logic [REG_W-1:0]  wr;
  } beat_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_t;

  state_t            state;
  state_t            state_n;
  beat_t             main_q;
  beat_t             skid_q;
  beat_t             beat_in;
  logic              ready_q;
  logic              pc_src_q;
  logic [DATA_W-1:0] target_q;
  logic              accept;
  logic              drain;
  logic              taken;
  logic              load_main;
  logic              load_skid;
  logic              skid_to_main;

  // Branches never write memory or registers in MEM.
  always_comb begin
    beat_in     = '0;
    beat_in.res = resultOut;
    beat_in.sd  = rt_data;
    beat_in.pc  = pcout;
    beat_in.mr  = mem_read & ~branch;
    beat_in.mw  = mem_write & ~branch;
    beat_in.rw  = reg_write & ~branch;
    beat_in.m2r = mem_to_reg;
    beat_in.wr  = write_reg;
  end

  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & ready_q & ~pc_src_q;
  assign drain     = out_valid & out_ready;
  assign taken     = accept & branch & zero;

  always_comb begin
    state_n      = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          state_n   = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (accept && !drain) begin
          state_n   = FULL;
          load_skid = 1'b1;
        end else if (accept && drain) begin
          load_main = 1'b1;
        end else if (drain) begin
          state_n = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          state_n      = ONE;
          skid_to_main = 1'b1;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= EMPTY;
      ready_q  <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
      pc_src_q <= 1'b0;
      target_q <= '0;
    end else begin
      state    <= state_n;
      ready_q  <= (state_n != FULL);
      pc_src_q <= taken;
      target_q <= taken ? address : '0;
      if (load_main)
        main_q <= beat_in;
      else if (skid_to_main)
        main_q <= skid_q;
      if (load_skid)
        skid_q <= beat_in;
    end
  end

  assign in_ready      = ready_q;
  assign m_result      = main_q.res;
  assign m_store_data  = main_q.sd;
  assign m_pc          = main_q.pc;
  assign m_mem_read    = main_q.mr;
  assign m_mem_write   = main_q.mw;
  assign m_reg_write   = main_q.rw;
  assign m_mem_to_reg  = main_q.m2r;
  assign m_write_reg   = main_q.wr;
  assign pc_src        = pc_src_q;
  assign flush         = pc_src_q;
  assign branch_target = target_q;

`ifdef EX_MEM_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      taken_cnt <= '0;
    end else begin
      if (out_valid && !out_ready)
        stall_cnt <= stall_cnt + 32'd1;
      if (pc_src_q)
        taken_cnt <= taken_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Testbench for ex_mem_stage: queue-based reference model plus directed
// literal checks for reset, branches, back-pressure and wrong-path beats.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] address;
  logic        zero;
  logic [31:0] resultOut;
  logic [31:0] pcout;
  logic        branch;
  logic [31:0] rt_data;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        mem_to_reg;
  logic [4:0]  write_reg;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] m_result;
  logic [31:0] m_store_data;
  logic [31:0] m_pc;
  logic        m_mem_read;
  logic        m_mem_write;
  logic        m_reg_write;
  logic        m_mem_to_reg;
  logic [4:0]  m_write_reg;
  logic        pc_src;
  logic [31:0] branch_target;
  logic        flush;
`ifdef EX_MEM_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] taken_cnt;
`endif

  always #5 clk = ~clk;

  ex_mem_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .address(address), .zero(zero), .resultOut(resultOut),
    .pcout(pcout), .branch(branch), .rt_data(rt_data),
    .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .write_reg(write_reg),
    .out_valid(out_valid), .out_ready(out_ready),
    .m_result(m_result), .m_store_data(m_store_data), .m_pc(m_pc),
    .m_mem_read(m_mem_read), .m_mem_write(m_mem_write),
    .m_reg_write(m_reg_write), .m_mem_to_reg(m_mem_to_reg),
    .m_write_reg(m_write_reg),
    .pc_src(pc_src), .branch_target(branch_target), .flush(flush)
`ifdef EX_MEM_PERF_EN
    , .stall_cnt(stall_cnt), .taken_cnt(taken_cnt)
`endif
  );

  typedef struct {
    logic [31:0] res;
    logic [31:0] sd;
    logic [31:0] pc;
    logic        mr;
    logic        mw;
    logic        rw;
    logic        m2r;
    logic [4:0]  wr;
  } exp_t;

  exp_t        q[$];
  logic        rdy_e;
  logic        pc_e;
  logic [31:0] tgt_e;
  logic        last_hs;
  logic [31:0] stall_e;
  logic [31:0] taken_e;
  logic        log_en;
  logic [31:0] drained[$];
  int          passed = 0;
  int          total = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic model_reset();
    q.delete();
    rdy_e   = 1'b0;
    pc_e    = 1'b0;
    tgt_e   = '0;
    last_hs = 1'b0;
    stall_e = '0;
    taken_e = '0;
  endtask

  function automatic exp_t mk();
    exp_t e;
    e.res = resultOut;
    e.sd  = rt_data;
    e.pc  = pcout;
    e.mr  = mem_read && !branch;
    e.mw  = mem_write && !branch;
    e.rw  = reg_write && !branch;
    e.m2r = mem_to_reg;
    e.wr  = write_reg;
    return e;
  endfunction

  // Predicts the effect of the coming clock edge from the driven inputs.
  task automatic model_step();
    logic acc;
    logic tk;
    if (reset) begin
      model_reset();
      return;
    end
    last_hs = in_valid && rdy_e;
    acc = last_hs && !pc_e;
    tk = acc && branch && zero;
    if (q.size() > 0 && !out_ready) stall_e = stall_e + 32'd1;
    if (pc_e) taken_e = taken_e + 32'd1;
    if (q.size() > 0 && out_ready) void'(q.pop_front());
    if (acc) q.push_back(mk());
    tgt_e = address;
    pc_e = tk;
    rdy_e = (q.size() < 2);
  endtask

  task automatic compare();
    chk("in_ready", 32'(in_ready), 32'(rdy_e));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("pc_src", 32'(pc_src), 32'(pc_e));
    chk("flush", 32'(flush), 32'(pc_e));
    if (pc_e) chk("branch_target", branch_target, tgt_e);
    if (q.size() > 0) begin
      chk("m_result", m_result, q[0].res);
      chk("m_store_data", m_store_data, q[0].sd);
      chk("m_pc", m_pc, q[0].pc);
      chk("m_mem_read", 32'(m_mem_read), 32'(q[0].mr));
      chk("m_mem_write", 32'(m_mem_write), 32'(q[0].mw));
      chk("m_reg_write", 32'(m_reg_write), 32'(q[0].rw));
      chk("m_mem_to_reg", 32'(m_mem_to_reg), 32'(q[0].m2r));
      chk("m_write_reg", 32'(m_write_reg), 32'(q[0].wr));
    end
`ifdef EX_MEM_PERF_EN
    chk("stall_cnt", stall_cnt, stall_e);
    chk("taken_cnt", taken_cnt, taken_e);
`endif
  endtask

  task automatic tick();
    if (log_en && out_valid && out_ready) drained.push_back(m_result);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic drive(input logic [31:0] res, input logic [4:0] wr,
                       input logic br, input logic z,
                       input logic [31:0] pc, input logic [31:0] adr,
                       input logic rw, input logic mw);
    resultOut  = res;
    write_reg  = wr;
    branch     = br;
    zero       = z;
    pcout      = pc;
    address    = adr;
    reg_write  = rw;
    mem_write  = mw;
    mem_read   = 1'b0;
    mem_to_reg = 1'b0;
    rt_data    = res + 32'd100;
    in_valid   = 1'b1;
  endtask

  task automatic send(input logic [31:0] res, input logic [4:0] wr,
                      input logic br, input logic z,
                      input logic [31:0] pc, input logic [31:0] adr,
                      input logic rw, input logic mw);
    drive(res, wr, br, z, pc, adr, rw, mw);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_hs) break;
    end
    chk("send_handshake", 32'(last_hs), 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    int n99;
    in_valid = 0; address = 0; zero = 0; resultOut = 0; pcout = 0;
    branch = 0; rt_data = 0; mem_read = 0; mem_write = 0;
    reg_write = 0; mem_to_reg = 0; write_reg = 0; out_ready = 0;
    log_en = 0;
    model_reset();
    #1 reset = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_pc_src", 32'(pc_src), 32'd0);
    chk("rst_m_result", m_result, 32'd0);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    compare();
    chk("rel_in_ready_low", 32'(in_ready), 32'd0);

    out_ready = 1'b1;
    send(32'd10, 5'd3, 0, 0, 32'd4, 32'd0, 1, 0);
    chk("basic_out_valid", 32'(out_valid), 32'd1);
    chk("basic_m_result", m_result, 32'd10);
    chk("basic_m_write_reg", 32'(m_write_reg), 32'd3);
    chk("basic_m_reg_write", 32'(m_reg_write), 32'd1);
    chk("basic_pc_src", 32'(pc_src), 32'd0);

    send(32'h55, 5'd7, 1, 1, 32'd8, 32'h1C, 1, 1);
    chk("taken_pc_src", 32'(pc_src), 32'd1);
    chk("taken_flush", 32'(flush), 32'd1);
    chk("taken_target", branch_target, 32'h1C);
    chk("taken_m_reg_write", 32'(m_reg_write), 32'd0);
    chk("taken_m_mem_write", 32'(m_mem_write), 32'd0);
    chk("taken_m_pc", m_pc, 32'd8);
    tick();
    chk("taken_pulse_end", 32'(pc_src), 32'd0);
    chk("taken_flush_end", 32'(flush), 32'd0);

    send(32'd20, 5'd4, 1, 0, 32'd12, 32'h40, 1, 1);
    chk("nt_pc_src", 32'(pc_src), 32'd0);
    chk("nt_m_reg_write", 32'(m_reg_write), 32'd0);
    chk("nt_m_result", m_result, 32'd20);
    tick();
    chk("nt_pc_src_after", 32'(pc_src), 32'd0);

    out_ready = 1'b0;
    send(32'd1, 5'd1, 0, 0, 32'd0, 32'd0, 1, 0);
    send(32'd2, 5'd2, 0, 0, 32'd0, 32'd0, 1, 0);
    chk("bp_full_in_ready", 32'(in_ready), 32'd0);
    drive(32'd3, 5'd3, 0, 0, 32'd0, 32'd0, 1, 0);
    tick();
    tick();
    chk("bp_held_in_ready", 32'(in_ready), 32'd0);
    chk("bp_held_m_result", m_result, 32'd1);
    drained.delete();
    log_en = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (last_hs) break;
    end
    chk("bp_third_hs", 32'(last_hs), 32'd1);
    in_valid = 1'b0;
    repeat (4) tick();
    log_en = 1'b0;
    chk("bp_drain_count", 32'(drained.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (drained.size() > i) chk("bp_order", drained[i], 32'(i + 1));

    drained.delete();
    log_en = 1'b1;
    send(32'd50, 5'd5, 1, 1, 32'd16, 32'h80, 1, 0);
    chk("wp_pc_src", 32'(pc_src), 32'd1);
    chk("wp_in_ready", 32'(in_ready), 32'd1);
    drive(32'd99, 5'd6, 0, 0, 32'd20, 32'd0, 1, 0);
    tick();
    chk("wp_consumed", 32'(last_hs), 32'd1);
    in_valid = 1'b0;
    repeat (3) tick();
    log_en = 1'b0;
    n99 = 0;
    foreach (drained[i]) if (drained[i] == 32'd99) n99++;
    chk("wp_99_absent", 32'(n99), 32'd0);
    chk("wp_drain_count", 32'(drained.size()), 32'd1);

    repeat (3000) begin
      in_valid   = ($urandom % 4) != 0;
      branch     = ($urandom % 4) == 0;
      zero       = $urandom % 2;
      out_ready  = ($urandom % 4) != 0;
      resultOut  = $urandom;
      rt_data    = $urandom;
      pcout      = $urandom;
      address    = $urandom;
      mem_read   = $urandom % 2;
      mem_write  = $urandom % 2;
      reg_write  = $urandom % 2;
      mem_to_reg = $urandom % 2;
      write_reg  = 5'($urandom);
      tick();
    end

    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    send(32'd7, 5'd7, 0, 0, 32'd28, 32'd0, 1, 0);
    send(32'd8, 5'd8, 0, 0, 32'd32, 32'd0, 1, 0);
    chk("mid_full_in_ready", 32'(in_ready), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("mid_in_ready", 32'(in_ready), 32'd0);
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_m_result", m_result, 32'd0);
    chk("mid_m_store_data", m_store_data, 32'd0);
    chk("mid_m_pc", m_pc, 32'd0);
    chk("mid_m_write_reg", 32'(m_write_reg), 32'd0);
    chk("mid_m_reg_write", 32'(m_reg_write), 32'd0);
    chk("mid_pc_src", 32'(pc_src), 32'd0);
    chk("mid_branch_target", branch_target, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    compare();
    tick();
    chk("post_in_ready", 32'(in_ready), 32'd1);
    chk("post_out_valid", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline register between the EX stage and the MEM stage of the 5-stage MIPS core.
- Captures EX results and forwards them with the control bits MEM needs.
- Decouples EX from MEM back-pressure with a 2-entry skid buffer.
- Resolves conditional branches (branch && zero) and issues a one-cycle redirect/flush to IF/ID.

Parameters:
- DATA_W, 32, width of address/result/pc/store-data paths
- REG_W, 5, width of destination register index

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  EX presents a valid instruction
- in_ready  out  1  stage can accept a beat this cycle
- address  in  DATA_W  EX branch target (pc+4 + sign_ext<<2)
- zero  in  1  EX ALU zero flag
- resultOut  in  DATA_W  EX ALU result
- pcout  in  DATA_W  EX pc+4
- branch  in  1  instruction is a conditional branch
- rt_data  in  DATA_W  store data
- mem_read, mem_write, reg_write, mem_to_reg  in  1 each  control bits from ID/EX
- write_reg  in  REG_W  destination register
- out_valid  out  1  MEM-side beat valid
- out_ready  in  1  MEM accepts beat
- m_result, m_store_data, m_pc  out  DATA_W each  registered resultOut/rt_data/pcout
- m_mem_read, m_mem_write, m_reg_write, m_mem_to_reg  out  1 each  registered controls
- m_write_reg  out  REG_W  registered destination
- pc_src  out  1  one-cycle pulse: take branch
- branch_target  out  DATA_W  target valid while pc_src=1
- flush  out  1  one-cycle pulse, equal to pc_src; kills IF/ID and ID/EX

Behaviour:
- Reset: asynchronous, active-high. All outputs go to 0 immediately, including in_ready=0; the FSM goes to EMPTY. in_ready becomes 1 on the first clock edge after reset deasserts. Any beat in flight during reset is discarded.
- Storage: main register (drives m_* outputs) plus one skid register.
- FSM states:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: out_valid=1, in_ready=1.
  - FULL: out_valid=1, in_ready=0.
- Transfer definitions: accept = in_valid && in_ready && !pc_src; drain = out_valid && out_ready.
- FSM transitions:
  - EMPTY: accept → ONE; the beat loads main.
  - ONE: accept && !drain → FULL; the beat loads skid.
  - ONE: accept && drain → ONE; the beat loads main.
  - ONE: drain && !accept → EMPTY.
  - FULL: drain → ONE; skid moves to main. No accept is possible in FULL.
- Latency: 1 cycle from accept to out_valid when EMPTY.
- in_ready is registered: it depends only on state, with no combinational path from out_ready.
- Ordering is strictly FIFO; no beat is duplicated or dropped except under the wrong-path rule below.
- Branch resolution, evaluated on accept:
  - If branch && zero, then on the next edge pc_src=1, flush=1 and branch_target=address, all for exactly one cycle.
  - The branch beat itself still enters the buffer with mem_read, mem_write and reg_write forced to 0.
- Wrong-path beat: a beat presented while pc_src=1 is consumed (in_ready is honoured) but not stored.
- Not-taken branches (branch && !zero) pass through with controls forced to 0 and no pulse.
- Back-to-back taken branches: the second branch arrives in the pc_src cycle, so it is dropped as wrong-path.
- A taken branch accepted while in ONE still pulses pc_src the next cycle, independent of MEM stall.
- Data paths are pure width-preserving registers; no arithmetic in this block.

Optional Feature:
- Macro: EX_MEM_PERF_EN.
- When defined, two extra outputs are added:
  - stall_cnt (32-bit): increments each cycle out_valid && !out_ready.
  - taken_cnt (32-bit): increments on each pc_src pulse.
- Both counters wrap at 2^32 and reset to 0.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset held 100 ns, then in_valid=1, resultOut=10, write_reg=3, reg_write=1, out_ready=1 → next cycle out_valid=1, m_result=10, m_write_reg=3, m_reg_write=1; pc_src stays 0.
- Taken branch: branch=1, zero=1, pcout=8, address=0x1C → one cycle later pc_src=1, flush=1, branch_target=0x1C for exactly one cycle; buffered beat has m_reg_write=0 and m_mem_write=0.
- Not-taken branch: branch=1, zero=0 → pc_src never asserts; beat drains with controls 0.
- Back-pressure: out_ready=0, push results 1,2 → in_ready=0 after the 2nd beat; third push is held. Release out_ready → outputs 1, 2, 3 in order; no loss or duplication.
- Wrong-path: taken branch followed by in_valid=1 with resultOut=99 in the pc_src cycle → 99 never appears on m_result.
- Reset asserted mid-operation with the FULL state held → all outputs 0 asynchronously, before the next clock edge; after release, out_valid=0 and in_ready=1 after one edge.
